cpu_seq_ctrl: RTL

- Multi-cycle instruction sequencer for the 8-bit register-file CPU datapath.
- Fetches 16-bit commands from instruction memory and decodes them.
- Drives register-file read/write ports and the data-memory write port through a FETCH/DECODE/EXEC/WB state machine.
- MUL runs as an iterative shift-add over DATA_WIDTH cycles. JUMP is conditional on a registered non-zero flag.

---
 rtl/cpu_seq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 8-bit register-file CPU.
// MUL is an iterative shift-add; JUMP is taken only when the last write-back result was non-zero.
module cpu_seq_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CMD_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [ADDR_WIDTH-1:0]     imem_addr,
  input  logic [CMD_WIDTH-1:0]      imem_data,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_a,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_b,
  input  logic [DATA_WIDTH-1:0]     rf_operand_a,
  input  logic [DATA_WIDTH-1:0]     rf_operand_b,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_write,
  output logic [DATA_WIDTH-1:0]     rf_data_in,
  output logic                      dmem_wen,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_data,
  output logic                      instr_done,
  output logic                      halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_XNOR = 4'b0010;
  localparam logic [3:0] OP_MOVE = 4'b0011;
  localparam logic [3:0] OP_JUMP = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CMD_WIDTH-1:0]  ir;
  logic                  nz_flag;
  logic [CNT_W-1:0]      mul_cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] result;
  logic [3:0]            opcode;

  assign opcode    = ir[15:12];
  assign imem_addr = pc;
  assign acc_next  = acc + (op_b[0] ? op_a : '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_MUL, OP_XNOR, OP_MOVE: state_next = S_EXEC;
          OP_HALT:                  state_next = S_HALTED;
          default:                  state_next = S_FETCH;
        endcase
      end
      S_EXEC: begin
        if (opcode == OP_MUL && mul_cnt != CNT_LAST) state_next = S_EXEC;
        else                                         state_next = S_WB;
      end
      S_WB:     state_next = S_FETCH;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_FETCH;
    endcase
  end

  // Datapath registers; operands are captured in DECODE so a later write-back cannot disturb them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      nz_flag <= 1'b0;
      mul_cnt <= '0;
      acc     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir <= imem_data;
          pc <= pc + 1'b1;
        end
        S_DECODE: begin
          op_a <= rf_operand_a;
          op_b <= rf_operand_b;
          if (opcode == OP_MUL) begin
            acc     <= '0;
            mul_cnt <= '0;
          end
          if (opcode == OP_JUMP && nz_flag) pc <= ADDR_WIDTH'(ir[7:0]);
        end
        S_EXEC: begin
          if (opcode == OP_MUL) begin
            acc     <= acc_next;
            result  <= acc_next;
            op_a    <= op_a << 1;
            op_b    <= op_b >> 1;
            mul_cnt <= mul_cnt + 1'b1;
          end else if (opcode == OP_XNOR) begin
            result <= ~(op_a ^ op_b);
          end else begin
            result <= op_a;
          end
        end
        S_WB: nz_flag <= (result != '0);
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    rf_addr_a     = '0;
    rf_addr_b     = '0;
    rf_wen        = 1'b0;
    rf_addr_write = '0;
    rf_data_in    = '0;
    dmem_wen      = 1'b0;
    dmem_addr     = '0;
    dmem_data     = '0;
    instr_done    = 1'b0;
    halted        = 1'b0;
    case (state)
      S_DECODE: begin
        rf_addr_a = (opcode == OP_MOVE) ? REG_ADDR_WIDTH'(ir[7:4]) : REG_ADDR_WIDTH'(ir[11:8]);
        rf_addr_b = REG_ADDR_WIDTH'(ir[7:4]);
        case (opcode)
          OP_MUL, OP_XNOR, OP_MOVE, OP_HALT: ;
          OP_LOAD: begin
            dmem_wen   = 1'b1;
            dmem_addr  = ADDR_WIDTH'(ir[11:8]);
            dmem_data  = DATA_WIDTH'(ir[7:0]);
            instr_done = 1'b1;
          end
          default: instr_done = 1'b1;
        endcase
      end
      S_WB: begin
        rf_wen        = 1'b1;
        rf_addr_write = (opcode == OP_MOVE) ? REG_ADDR_WIDTH'(ir[11:8]) : REG_ADDR_WIDTH'(ir[3:0]);
        rf_data_in    = result;
        instr_done    = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
